// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between the two UART TX requesters, the arbiter and the UART transmit port.
// The arbiter connects through the slave modport; the surrounding environment uses the master modport.
interface uart_tx_arbiter_if;
    logic [7:0] Req0Data;
    logic       Req0Valid;
    logic       Req0Ready;
    logic [7:0] Req1Data;
    logic       Req1Valid;
    logic       Req1Ready;
    logic [7:0] DataIn;
    logic       DataInValid;
    logic       DataInReady;
    logic [1:0] Grant;

    modport master (
        output Req0Data, Req0Valid, Req1Data, Req1Valid, DataInReady,
        input  Req0Ready, Req1Ready, DataIn, DataInValid, Grant
    );

    modport slave (
        input  Req0Data, Req0Valid, Req1Data, Req1Valid, DataInReady,
        output Req0Ready, Req1Ready, DataIn, DataInValid, Grant
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-aware round-robin arbiter sharing the UART TX port between CPU (req 0) and debug source (req 1).
// Optional statistics counters are enabled with `define UART_ARB_STATS_EN.
module uart_tx_arbiter #(
    parameter logic [7:0]  EopByte     = 8'h0A,
    parameter int unsigned MaxBurst    = 64,
    parameter int unsigned IdleTimeout = 1024
) (
    input logic Clock,
    input logic Reset,
    uart_tx_arbiter_if.slave bus
`ifdef UART_ARB_STATS_EN
    ,
    output logic [15:0] Stat0Bytes,
    output logic [15:0] Stat1Bytes,
    output logic [7:0]  StatTimeouts
`endif
);

    localparam int unsigned     IdleW      = $clog2(IdleTimeout + 1);
    localparam logic [IdleW-1:0] IdleLast  = IdleW'(IdleTimeout - 1);
    localparam logic [IdleW-1:0] IdleOne   = IdleW'(1);
    localparam logic [7:0]      BurstLimit = 8'(MaxBurst);

    typedef enum logic [1:0] {
        Idle   = 2'd0,
        Grant0 = 2'd1,
        Grant1 = 2'd2
    } arbStateT;

    arbStateT         state, stateNext;
    logic             ptr;
    logic [7:0]       burstCnt;
    logic [IdleW-1:0] idleCnt;
    logic             outFree;
    logic             accept;
    logic [7:0]       acceptByte;
    logic             releaseGrant;
    logic             timeout;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= Idle;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext     = state;
        bus.Req0Ready = 1'b0;
        bus.Req1Ready = 1'b0;
        bus.Grant     = 2'b00;
        accept        = 1'b0;
        acceptByte    = '0;
        releaseGrant  = 1'b0;
        timeout       = 1'b0;
        outFree       = !bus.DataInValid || bus.DataInReady;
        case (state)
            Idle: begin
                if (bus.Req0Valid && (!bus.Req1Valid || !ptr)) stateNext = Grant0;
                else if (bus.Req1Valid)                         stateNext = Grant1;
            end
            Grant0: begin
                bus.Grant     = 2'b01;
                bus.Req0Ready = bus.Req0Valid && outFree;
                accept        = bus.Req0Ready;
                acceptByte    = bus.Req0Data;
            end
            Grant1: begin
                bus.Grant     = 2'b10;
                bus.Req1Ready = bus.Req1Valid && outFree;
                accept        = bus.Req1Ready;
                acceptByte    = bus.Req1Data;
            end
            default: stateNext = Idle;
        endcase
        // An accept clears the idle counter, so EOP/burst and timeout can never both fire.
        if (state == Grant0 || state == Grant1) begin
            if (accept) begin
                releaseGrant = (acceptByte == EopByte) || (burstCnt + 8'd1 == BurstLimit);
            end else if (idleCnt == IdleLast) begin
                releaseGrant = 1'b1;
                timeout      = 1'b1;
            end
        end
        if (releaseGrant) stateNext = Idle;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            bus.DataIn      <= '0;
            bus.DataInValid <= 1'b0;
            burstCnt        <= '0;
            idleCnt         <= '0;
            ptr             <= 1'b0;
        end else begin
            if (accept) begin
                bus.DataIn      <= acceptByte;
                bus.DataInValid <= 1'b1;
            end else if (bus.DataInReady) begin
                bus.DataInValid <= 1'b0;
            end
            // Counters sit at zero while idle, which clears them on grant entry.
            if (state == Idle) begin
                burstCnt <= '0;
                idleCnt  <= '0;
            end else if (accept) begin
                burstCnt <= burstCnt + 8'd1;
                idleCnt  <= '0;
            end else begin
                idleCnt <= idleCnt + IdleOne;
            end
            if (releaseGrant) ptr <= (state == Grant0);
        end
    end

`ifdef UART_ARB_STATS_EN
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Stat0Bytes   <= '0;
            Stat1Bytes   <= '0;
            StatTimeouts <= '0;
        end else begin
            if (accept && state == Grant0) Stat0Bytes <= Stat0Bytes + 16'd1;
            if (accept && state == Grant1) Stat1Bytes <= Stat1Bytes + 16'd1;
            if (timeout && StatTimeouts != 8'hFF) StatTimeouts <= StatTimeouts + 8'd1;
        end
    end
`endif

endmodule
